// File: rtl/ugemm_rate_ctrl_if.sv
// rtl/ugemm_rate_ctrl_if.sv - request/result bundle between a unary GEMM window user and its rate controller
interface ugemm_rate_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             i_start;
  logic [WIDTH:0]   i_len;
  logic             i_clear;
  logic             i_bit;
  logic             i_ready;
  logic             o_en;
  logic [WIDTH-1:0] o_randW;
  logic [WIDTH-1:0] o_randW_inv;
  logic             o_busy;
  logic             o_valid;
  logic [WIDTH:0]   o_sum;
  logic [WIDTH:0]   o_len;

  modport master (
    output i_start, i_len, i_clear, i_bit, i_ready,
    input  o_en, o_randW, o_randW_inv, o_busy, o_valid, o_sum, o_len
  );

  modport slave (
    input  i_start, i_len, i_clear, i_bit, i_ready,
    output o_en, o_randW, o_randW_inv, o_busy, o_valid, o_sum, o_len
  );
endinterface

// File: rtl/ugemm_rate_ctrl.sv
// rtl/ugemm_rate_ctrl.sv - sequencer for one rate-coded unary GEMM MAC window
module ugemm_rate_ctrl #(
  parameter int WIDTH = 8,
  parameter int LAT   = 1
) (
  input logic              clk,
  input logic              rst_n,
  ugemm_rate_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [WIDTH:0] FULL_LEN = {1'b1, {WIDTH{1'b0}}};
  localparam logic [LAT-1:0] EN_TAIL  = LAT'(1) << (LAT - 1);

  state_t           state;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   len_q;
  logic [LAT-1:0]   en_d;

  logic [WIDTH:0]   len_in;
  logic [WIDTH-1:0] rev;
  logic             accept;

  assign len_in = (bus.i_len == '0) ? FULL_LEN : bus.i_len;
  assign accept = bus.i_start && ((state == IDLE) || ((state == DONE) && bus.i_ready));

  always_comb begin
    rev = '0;
    for (int i = 0; i < WIDTH; i++) rev[i] = cnt[WIDTH-1-i];
  end

  // cnt stops on the last RUN cycle, so the operand naturally holds through DRAIN/DONE
  assign bus.o_en        = (state == RUN);
  assign bus.o_busy      = (state != IDLE);
  assign bus.o_valid     = (state == DONE);
  assign bus.o_randW     = (state == IDLE) ? '0 : rev;
  assign bus.o_randW_inv = (state == IDLE) ? '0 : ~rev;
  assign bus.o_sum       = sum;
  assign bus.o_len       = len_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      sum   <= '0;
      len_q <= '0;
      en_d  <= '0;
    end else if (bus.i_clear) begin
      state <= IDLE;
      cnt   <= '0;
      sum   <= '0;
      en_d  <= '0;
    end else begin
      en_d <= (en_d << 1) | LAT'(state == RUN);
      if (accept) begin
        len_q <= len_in;
        cnt   <= '0;
        sum   <= '0;
        state <= RUN;
      end else begin
        if (en_d[LAT-1]) sum <= sum + (WIDTH+1)'(bus.i_bit);
        case (state)
          RUN: begin
            if ({1'b0, cnt} == len_q - (WIDTH+1)'(1)) state <= DRAIN;
            else cnt <= cnt + WIDTH'(1);
          end
          // the last counted bit is in flight exactly when only the oldest tap is set
          DRAIN: if (en_d == EN_TAIL) state <= DONE;
          DONE:  if (bus.i_ready) state <= IDLE;
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_ugemm_rate_ctrl.sv
// tb/tb_ugemm_rate_ctrl.sv - self-checking bench for ugemm_rate_ctrl (LAT=1 and LAT=3 side by side)
module tb_ugemm_rate_ctrl;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         start = 1'b0;
  logic         clr   = 1'b0;
  logic         rdy   = 1'b0;
  logic [W:0]   len   = '0;
  logic         bit1  = 1'b0;
  logic         bit3  = 1'b0;
  logic [3:0]   h1    = '0;
  logic [3:0]   h3    = '0;
  logic [7:0]   rw_seen [4];
  logic [7:0]   ri_seen [4];

  int total = 0;
  int bad   = 0;

  ugemm_rate_ctrl_if #(.WIDTH(W)) if1 ();
  ugemm_rate_ctrl_if #(.WIDTH(W)) if3 ();

  assign if1.i_start = start;
  assign if1.i_len   = len;
  assign if1.i_clear = clr;
  assign if1.i_ready = rdy;
  assign if1.i_bit   = bit1;
  assign if3.i_start = start;
  assign if3.i_len   = len;
  assign if3.i_clear = clr;
  assign if3.i_ready = rdy;
  assign if3.i_bit   = bit3;

  ugemm_rate_ctrl #(.WIDTH(W), .LAT(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  ugemm_rate_ctrl #(.WIDTH(W), .LAT(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(if3));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int rev8(input int v);
    int r = 0;
    for (int i = 0; i < 8; i++) if (v[i]) r = r | (1 << (7 - i));
    return r;
  endfunction

  // ones produced by a weight-w multiplier: how many window indices map to an operand below w
  function automatic int wcount(input int n, input int w);
    int k = 0;
    for (int i = 0; i < n; i++) if (rev8(i) < w) k++;
    return k;
  endfunction

  task automatic chk_zero(input string tag);
    chk({tag, "_en1"},    32'(if1.o_en),        0);
    chk({tag, "_rw1"},    32'(if1.o_randW),     0);
    chk({tag, "_ri1"},    32'(if1.o_randW_inv), 0);
    chk({tag, "_busy1"},  32'(if1.o_busy),      0);
    chk({tag, "_valid1"}, 32'(if1.o_valid),     0);
    chk({tag, "_sum1"},   32'(if1.o_sum),       0);
    chk({tag, "_len1"},   32'(if1.o_len),       0);
    chk({tag, "_en3"},    32'(if3.o_en),        0);
    chk({tag, "_busy3"},  32'(if3.o_busy),      0);
    chk({tag, "_valid3"}, 32'(if3.o_valid),     0);
    chk({tag, "_sum3"},   32'(if3.o_sum),       0);
    chk({tag, "_ri3"},    32'(if3.o_randW_inv), 0);
  endtask

  task automatic launch(input int n);
    @(negedge clk);
    start = 1'b1;
    len   = (W+1)'(n);
    rdy   = 1'b0;
    h1    = '0;
    h3    = '0;
    @(posedge clk);
  endtask

  // mode 0: bit always 1, mode 1: random bits, mode 2: weight-w multiplier fed from o_randW
  task automatic body(input string tag, input int n, input int mode, input int w);
    int le = (n == 0) ? 256 : n;
    int e1 = 0, e3 = 0, enbad1 = 0, enbad3 = 0, vbad1 = 0, vbad3 = 0;
    for (int c = 0; c < le + 4; c++) begin
      @(negedge clk);
      start = 1'b0;
      rdy   = 1'b0;
      if (if1.o_en !== (c < le)) enbad1++;
      if (if3.o_en !== (c < le)) enbad3++;
      if (if1.o_valid !== (c >= le + 1)) vbad1++;
      if (if3.o_valid !== (c >= le + 3)) vbad3++;
      if (c < 4) begin
        rw_seen[c[1:0]] = if1.o_randW;
        ri_seen[c[1:0]] = if1.o_randW_inv;
      end
      h1 = {h1[2:0], if1.o_en & (32'(if1.o_randW) < w)};
      h3 = {h3[2:0], if3.o_en & (32'(if3.o_randW) < w)};
      case (mode)
        0:       begin bit1 = 1'b1; bit3 = 1'b1; end
        1:       begin bit1 = 1'($urandom_range(0, 1)); bit3 = 1'($urandom_range(0, 1)); end
        default: begin bit1 = h1[1]; bit3 = h3[3]; end
      endcase
      if (c >= 1 && c < le + 1 && bit1) e1++;
      if (c >= 3 && c < le + 3 && bit3) e3++;
    end
    if (mode == 2) begin
      e1 = wcount(le, w);
      e3 = e1;
    end
    chk({tag, "_en_pattern1"},    32'(enbad1), 0);
    chk({tag, "_en_pattern3"},    32'(enbad3), 0);
    chk({tag, "_valid_timing1"},  32'(vbad1),  0);
    chk({tag, "_valid_timing3"},  32'(vbad3),  0);
    chk({tag, "_sum1"},           32'(if1.o_sum), 32'(e1));
    chk({tag, "_sum3"},           32'(if3.o_sum), 32'(e3));
    chk({tag, "_len1"},           32'(if1.o_len), 32'(le));
    chk({tag, "_len3"},           32'(if3.o_len), 32'(le));
  endtask

  task automatic hs(input string tag);
    @(negedge clk);
    rdy = 1'b1;
    @(negedge clk);
    rdy = 1'b0;
    chk({tag, "_hs_valid1"}, 32'(if1.o_valid), 0);
    chk({tag, "_hs_valid3"}, 32'(if3.o_valid), 0);
    chk({tag, "_hs_busy1"},  32'(if1.o_busy),  0);
    chk({tag, "_hs_busy3"},  32'(if3.o_busy),  0);
  endtask

  initial begin
    logic [W:0] s1, s3;
    int nv;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;

    launch(256); body("full_ones", 256, 0, 0); hs("full_ones");

    launch(256); body("w128", 256, 2, 128);
    chk("w128_sum_const", 32'(if1.o_sum), 128);
    chk("rw0", 32'(rw_seen[0]), 0);
    chk("rw1", 32'(rw_seen[1]), 128);
    chk("rw2", 32'(rw_seen[2]), 64);
    chk("rw3", 32'(rw_seen[3]), 192);
    chk("ri0", 32'(ri_seen[0]), 255);
    chk("ri1", 32'(ri_seen[1]), 127);
    chk("ri2", 32'(ri_seen[2]), 191);
    chk("ri3", 32'(ri_seen[3]), 63);
    hs("w128");

    launch(1); body("len1", 1, 0, 0); hs("len1");
    launch(0); body("len0", 0, 1, 0); hs("len0");

    for (int k = 0; k < 5; k++) begin
      int n = $urandom_range(1, 256);
      launch(n); body("rand", n, 1, 0); hs("rand");
    end
    for (int k = 0; k < 2; k++) begin
      int n = $urandom_range(1, 256);
      int w = $urandom_range(0, 256);
      launch(n); body("rweight", n, 2, w); hs("rweight");
    end

    launch(40); body("bp", 40, 1, 0);
    s1 = if1.o_sum;
    s3 = if3.o_sum;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_valid1", 32'(if1.o_valid), 1);
      chk("bp_valid3", 32'(if3.o_valid), 1);
      chk("bp_sum1",   32'(if1.o_sum), 32'(s1));
      chk("bp_sum3",   32'(if3.o_sum), 32'(s3));
      chk("bp_noen1",  32'(if1.o_en), 0);
      start = (i == 4);
    end
    @(negedge clk);
    chk("bp_start_ignored1", 32'(if1.o_en), 0);
    chk("bp_start_ignored3", 32'(if3.o_valid), 1);
    start = 1'b1;
    rdy   = 1'b1;
    len   = (W+1)'(16);
    h1    = '0;
    h3    = '0;
    @(posedge clk);
    body("b2b", 16, 0, 0); hs("b2b");

    launch(200);
    for (int c = 0; c <= 100; c++) begin
      @(negedge clk);
      start = 1'b0;
      clr   = (c == 100);
    end
    @(posedge clk);
    @(negedge clk);
    clr = 1'b0;
    chk("clr_en1",    32'(if1.o_en),    0);
    chk("clr_busy1",  32'(if1.o_busy),  0);
    chk("clr_valid1", 32'(if1.o_valid), 0);
    chk("clr_sum1",   32'(if1.o_sum),   0);
    chk("clr_en3",    32'(if3.o_en),    0);
    chk("clr_busy3",  32'(if3.o_busy),  0);
    chk("clr_sum3",   32'(if3.o_sum),   0);
    nv = 0;
    for (int c = 0; c < 260; c++) begin
      @(negedge clk);
      if (if1.o_valid || if3.o_valid || if1.o_busy || if3.o_busy) nv++;
    end
    chk("clr_no_result", 32'(nv), 0);
    launch(16); body("after_clr", 16, 0, 0); hs("after_clr");

    launch(8);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      start = 1'b0;
      bit1  = 1'b1;
      bit3  = 1'b1;
    end
    chk("mid_run_en3", 32'(if3.o_en), 1);
    #1 rst_n = 1'b0;
    #1 chk_zero("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_zero("post_rst");
    launch(8); body("recover", 8, 1, 0); hs("recover");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
